dr_data_port_responder: RTL and testbench

- Clocked responder for the processor's dual-rail, four-phase, return-to-zero data-memory interface.
- The processor is the active party. It pushes Access, Mode and (for writes) Do. This block acknowledges them, performs the access on a synchronous single-port SRAM, then pushes Abort and (for reads) Di back.
- It replaces the behavioural dual-port memory's data side in synthesisable FPGA/ASIC test harnesses.

---
 rtl/dr_data_port_responder.sv | 219 +++++++++++++++++++++
 tb/tb_dr_data_port_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_data_port_responder.sv
// rtl/dr_data_port_responder.sv - dual-rail four-phase data port responder backed by a single-port SRAM
// Synchronises all incoming rails and acks, detects complete codewords and spacers,
// performs one SRAM access per transaction and pushes abort/di back dual-rail.
module dr_data_port_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] ABORT_BASE  = 32'hFFFF_0000,
  parameter int          MEM_AW      = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [37:0]       access_0r0d,
  input  logic [37:0]       access_0r1d,
  output logic              access_0a,
  input  logic              mode_0r0d,
  input  logic              mode_0r1d,
  output logic              mode_0a,
  input  logic [31:0]       do_0r0d,
  input  logic [31:0]       do_0r1d,
  output logic              do_0a,
  output logic [31:0]       di_0r0d,
  output logic [31:0]       di_0r1d,
  input  logic              di_0a,
  output logic              abort_0r0d,
  output logic              abort_0r1d,
  input  logic              abort_0a,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              proto_err
);

  localparam int IN_W = 38 * 2 + 2 + 32 * 2 + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_MEM, S_WAIT, S_RESP, S_RTZ
  } state_e;

  // Synchroniser chain covering every incoming rail and ack
  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic [IN_W-1:0] raw_in;
  logic [37:0]     a1, a0;
  logic            m1, m0;
  logic [31:0]     d1, d0;
  logic            di_ack, ab_ack;

  assign raw_in = {access_0r1d, access_0r0d, mode_0r1d, mode_0r0d,
                   do_0r1d, do_0r0d, di_0a, abort_0a};
  assign {a1, a0, m1, m0, d1, d0, di_ack, ab_ack} = sync_q[SYNC_STAGES-1];

  // Shift all raw inputs through SYNC_STAGES flops
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Completion / spacer detection on the synchronised rails
  logic a_comp, a_spc, m_comp, m_spc, d_comp, d_spc, proto_now, req_go;
  assign a_comp    = &(a1 ^ a0);
  assign a_spc     = ~|(a1 | a0);
  assign m_comp    = m1 ^ m0;
  assign m_spc     = ~(m1 | m0);
  assign d_comp    = &(d1 ^ d0);
  assign d_spc     = ~|(d1 | d0);
  assign proto_now = (|(a1 & a0)) | (m1 & m0) | (|(d1 & d0));
  assign req_go    = a_comp && m_comp && (!a1[34] || d_comp);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d, mode_q, mode_d, proto_q;
  logic        capture, abort_hit;
  logic [3:0]  be;

  // Mode is carried for completeness only; the access does not depend on it
  logic unused_mode;
  assign unused_mode = mode_q;

  assign capture   = (state_q == S_IDLE) && req_go;
  assign abort_hit = (addr_q >= ABORT_BASE) || (size_q == 2'b11);

  // Request capture in IDLE, read data latch in WAIT
  always_comb begin
    addr_d  = capture ? a1[31:0]  : addr_q;
    size_d  = capture ? a1[33:32] : size_q;
    wr_d    = capture ? a1[34]    : wr_q;
    wdata_d = capture ? d1        : wdata_q;
    mode_d  = capture ? m1        : mode_q;
    rdata_d = (state_q == S_WAIT) ? mem_rdata : rdata_q;
  end

  // Byte enables from size and low address bits
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'b00:   be = 4'b0001 << addr_q[1:0];
      2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_go) state_d = S_ACK;
      S_ACK:  if (a_spc && m_spc && (!wr_q || d_spc)) state_d = S_MEM;
      S_MEM:  state_d = wr_q ? S_RESP : S_WAIT;
      S_WAIT: state_d = S_RESP;
      S_RESP: if (ab_ack && (wr_q || di_ack)) state_d = S_RTZ;
      S_RTZ:  if (!ab_ack && (wr_q || !di_ack)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so every rail changes on one edge, glitch-free
  logic              acc_ack_d, mode_ack_d, do_ack_d, ab1_d, ab0_d, men_d, mwe_d;
  logic [31:0]       di1_d, di0_d, mwdata_d, di_val;
  logic [3:0]        mbe_d;
  logic [MEM_AW-1:0] maddr_d;
  always_comb begin
    acc_ack_d  = 1'b0;
    mode_ack_d = 1'b0;
    do_ack_d   = 1'b0;
    ab1_d      = 1'b0;
    ab0_d      = 1'b0;
    di1_d      = '0;
    di0_d      = '0;
    di_val     = '0;
    men_d      = 1'b0;
    mwe_d      = 1'b0;
    mbe_d      = '0;
    maddr_d    = '0;
    mwdata_d   = '0;
    case (state_d)
      S_ACK: begin
        acc_ack_d  = 1'b1;
        mode_ack_d = 1'b1;
        do_ack_d   = wr_d;
      end
      S_MEM: begin
        if (!abort_hit) begin
          men_d    = 1'b1;
          mwe_d    = wr_q;
          mbe_d    = be;
          maddr_d  = addr_q[MEM_AW+1:2];
          mwdata_d = wdata_q;
        end
      end
      S_RESP: begin
        ab1_d = abort_hit;
        ab0_d = !abort_hit;
        if (!wr_q) begin
          di_val = abort_hit ? 32'h0 : rdata_d;
          di1_d  = di_val;
          di0_d  = ~di_val;
        end
      end
      default: ;
    endcase
  end

  // State, captured data, registered outputs and sticky protocol error
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mode_q     <= 1'b0;
      proto_q    <= 1'b0;
      access_0a  <= 1'b0;
      mode_0a    <= 1'b0;
      do_0a      <= 1'b0;
      abort_0r1d <= 1'b0;
      abort_0r0d <= 1'b0;
      di_0r1d    <= '0;
      di_0r0d    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mode_q     <= mode_d;
      proto_q    <= proto_q | proto_now;
      access_0a  <= acc_ack_d;
      mode_0a    <= mode_ack_d;
      do_0a      <= do_ack_d;
      abort_0r1d <= ab1_d;
      abort_0r0d <= ab0_d;
      di_0r1d    <= di1_d;
      di_0r0d    <= di0_d;
      mem_en     <= men_d;
      mem_we     <= mwe_d;
      mem_be     <= mbe_d;
      mem_addr   <= maddr_d;
      mem_wdata  <= mwdata_d;
    end
  end

  assign proto_err = proto_q;

endmodule

// File: tb/tb_dr_data_port_responder.sv
// tb/tb_dr_data_port_responder.sv - directed self-checking bench for dr_data_port_responder
module tb_dr_data_port_responder;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        nreset;
  logic [37:0] access_0r0d, access_0r1d;
  logic        access_0a, mode_0r0d, mode_0r1d, mode_0a;
  logic [31:0] do_0r0d, do_0r1d;
  logic        do_0a;
  logic [31:0] di_0r0d, di_0r1d;
  logic        di_0a, abort_0r0d, abort_0r1d, abort_0a;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        proto_err;

  always #5 clk = ~clk;

  dr_data_port_responder #(.SYNC_STAGES(SS), .ABORT_BASE(32'hFFFF_0000), .MEM_AW(16)) dut (
    .clk(clk), .nreset(nreset),
    .access_0r0d(access_0r0d), .access_0r1d(access_0r1d), .access_0a(access_0a),
    .mode_0r0d(mode_0r0d), .mode_0r1d(mode_0r1d), .mode_0a(mode_0a),
    .do_0r0d(do_0r0d), .do_0r1d(do_0r1d), .do_0a(do_0a),
    .di_0r0d(di_0r0d), .di_0r1d(di_0r1d), .di_0a(di_0a),
    .abort_0r0d(abort_0r0d), .abort_0r1d(abort_0r1d), .abort_0a(abort_0a),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  // SRAM model with access capture
  logic [31:0] sram [0:65535];
  int          en_cnt = 0;
  int          di_cnt = 0;
  logic [15:0] cap_addr = '0;
  logic [3:0]  cap_be = '0;
  logic [31:0] cap_wdata = '0;
  logic        cap_we = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) begin : mdl
    logic [31:0] w;
    if (mem_en) begin
      en_cnt    <= en_cnt + 1;
      cap_addr  <= mem_addr;
      cap_be    <= mem_be;
      cap_wdata <= mem_wdata;
      cap_we    <= mem_we;
      if (mem_we) begin
        w = sram[mem_addr];
        for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        sram[mem_addr] <= w;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(negedge clk) if ((di_0r0d | di_0r1d) != 32'h0) di_cnt <= di_cnt + 1;

  task automatic drive_req(input logic [31:0] addr, input logic [1:0] size,
                           input logic wr, input logic [31:0] data);
    logic [37:0] v;
    v = {3'b000, wr, size, addr};
    access_0r1d = v;
    access_0r0d = ~v;
    mode_0r1d = 1'b1;
    mode_0r0d = 1'b0;
    if (wr) begin
      do_0r1d = data;
      do_0r0d = ~data;
    end
  endtask

  task automatic drop_req();
    access_0r1d = '0; access_0r0d = '0;
    mode_0r1d = 1'b0; mode_0r0d = 1'b0;
    do_0r1d = '0; do_0r0d = '0;
  endtask

  task automatic wait_ack(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (access_0a === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_resp(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((abort_0r0d | abort_0r1d) === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rtz(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ({abort_0r0d, abort_0r1d, di_0r0d, di_0r1d} === '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                         input logic [31:0] data, output logic ok, output logic [1:0] ab,
                         output logic [31:0] r1, output logic [31:0] r0);
    logic o1, o2, o3;
    @(negedge clk);
    drive_req(addr, size, wr, data);
    wait_ack(o1);
    drop_req();
    wait_resp(o2);
    ab = {abort_0r1d, abort_0r0d};
    r1 = di_0r1d;
    r0 = di_0r0d;
    abort_0a = 1'b1;
    di_0a = !wr;
    wait_rtz(o3);
    abort_0a = 1'b0;
    di_0a = 1'b0;
    repeat (SS + 3) @(negedge clk);
    ok = o1 & o2 & o3;
  endtask

  task automatic test_reset();
    n_chk++;
    if ((|{access_0a, mode_0a, do_0a, di_0r0d, di_0r1d, abort_0r0d, abort_0r1d,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata, proto_err}) !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero output, expected all zero");
    end
    @(negedge clk); nreset = 1'b1;
    repeat (SS + 2) @(negedge clk);
    n_chk++;
    if ({access_0a, mem_en, abort_0r0d, abort_0r1d, proto_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 00000",
                         {access_0a, mem_en, abort_0r0d, abort_0r1d, proto_err});
    end
  endtask

  task automatic test_word_write();
    logic ok; logic [1:0] ab; logic [31:0] r1, r0; int e0, dc;
    e0 = en_cnt; dc = di_cnt;
    run_txn(32'h100, 2'b10, 1'b1, 32'hDEADBEEF, ok, ab, r1, r0);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ww_handshake: got %b expected 1", ok); end
    n_chk++; if (en_cnt - e0 != 1) begin n_fail++; $display("FAIL ww_mem_en: got %0d expected 1", en_cnt - e0); end
    n_chk++; if (cap_addr !== 16'h0040) begin n_fail++; $display("FAIL ww_addr: got %h expected 0040", cap_addr); end
    n_chk++; if (cap_be !== 4'b1111) begin n_fail++; $display("FAIL ww_be: got %b expected 1111", cap_be); end
    n_chk++; if (cap_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ww_wdata: got %h expected deadbeef", cap_wdata); end
    n_chk++; if (cap_we !== 1'b1) begin n_fail++; $display("FAIL ww_we: got %b expected 1", cap_we); end
    n_chk++; if (ab !== 2'b01) begin n_fail++; $display("FAIL ww_abort: got %b expected 01", ab); end
    n_chk++; if (di_cnt != dc) begin n_fail++; $display("FAIL ww_di_driven: got %0d cycles expected 0", di_cnt - dc); end
    n_chk++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL ww_proto: got %b expected 0", proto_err); end
  endtask

  task automatic test_byte_read();
    logic ok; logic [1:0] ab; logic [31:0] r1, r0; int e0;
    run_txn(32'h100, 2'b10, 1'b1, 32'h11223344, ok, ab, r1, r0);
    e0 = en_cnt;
    run_txn(32'h102, 2'b00, 1'b0, 32'h0, ok, ab, r1, r0);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL br_handshake: got %b expected 1", ok); end
    n_chk++; if (en_cnt - e0 != 1) begin n_fail++; $display("FAIL br_mem_en: got %0d expected 1", en_cnt - e0); end
    n_chk++; if ({cap_we, cap_be, cap_addr} !== {1'b0, 4'b0100, 16'h0040}) begin
      n_fail++; $display("FAIL br_access: got we=%b be=%b addr=%h expected we=0 be=0100 addr=0040", cap_we, cap_be, cap_addr);
    end
    n_chk++; if (r1 !== 32'h11223344) begin n_fail++; $display("FAIL br_di1: got %h expected 11223344", r1); end
    n_chk++; if (r0 !== 32'hEEDDCCBB) begin n_fail++; $display("FAIL br_di0: got %h expected eeddccbb", r0); end
    n_chk++; if (ab !== 2'b01) begin n_fail++; $display("FAIL br_abort: got %b expected 01", ab); end
  endtask

  task automatic test_half_write();
    logic ok; logic [1:0] ab; logic [31:0] r1, r0;
    run_txn(32'h104, 2'b10, 1'b1, 32'hAABBCCDD, ok, ab, r1, r0);
    run_txn(32'h107, 2'b01, 1'b1, 32'h55660000, ok, ab, r1, r0);
    n_chk++; if ({cap_be, cap_addr} !== {4'b1100, 16'h0041}) begin
      n_fail++; $display("FAIL hw_access: got be=%b addr=%h expected be=1100 addr=0041", cap_be, cap_addr);
    end
    run_txn(32'h105, 2'b10, 1'b0, 32'h0, ok, ab, r1, r0);
    n_chk++; if (cap_be !== 4'b1111) begin n_fail++; $display("FAIL hw_word_be: got %b expected 1111", cap_be); end
    n_chk++; if (r1 !== 32'h5566CCDD) begin n_fail++; $display("FAIL hw_readback: got %h expected 5566ccdd", r1); end
  endtask

  task automatic test_abort();
    logic ok; logic [1:0] ab; logic [31:0] r1, r0; int e0, dc;
    e0 = en_cnt;
    run_txn(32'hFFFF_0004, 2'b10, 1'b0, 32'h0, ok, ab, r1, r0);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ab_handshake: got %b expected 1", ok); end
    n_chk++; if (en_cnt != e0) begin n_fail++; $display("FAIL ab_mem_en: got %0d expected 0", en_cnt - e0); end
    n_chk++; if (ab !== 2'b10) begin n_fail++; $display("FAIL ab_abort: got %b expected 10", ab); end
    n_chk++; if ({r1, r0} !== {32'h0, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL ab_di: got %h/%h expected 00000000/ffffffff", r1, r0);
    end
    run_txn(32'hFFFF_0000, 2'b10, 1'b0, 32'h0, ok, ab, r1, r0);
    n_chk++; if ({ab, en_cnt - e0} !== {2'b10, 32'd0}) begin
      n_fail++; $display("FAIL ab_base: got abort=%b accesses=%0d expected 10 and 0", ab, en_cnt - e0);
    end
    run_txn(32'hFFFE_FFFC, 2'b10, 1'b0, 32'h0, ok, ab, r1, r0);
    n_chk++; if ({ab, cap_addr, en_cnt - e0} !== {2'b01, 16'hBFFF, 32'd1}) begin
      n_fail++; $display("FAIL ab_below: got abort=%b addr=%h accesses=%0d expected 01 bfff 1", ab, cap_addr, en_cnt - e0);
    end
    e0 = en_cnt; dc = di_cnt;
    run_txn(32'h200, 2'b11, 1'b1, 32'h12345678, ok, ab, r1, r0);
    n_chk++; if ({ab, en_cnt - e0, di_cnt - dc} !== {2'b10, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL ab_size11: got abort=%b accesses=%0d di=%0d expected 10 0 0", ab, en_cnt - e0, di_cnt - dc);
    end
  endtask

  task automatic test_slow();
    logic ok, o2, o3, bad_hold, bad_stable; logic [67:0] snap; int e0;
    e0 = en_cnt; bad_hold = 1'b0; bad_stable = 1'b0;
    @(negedge clk);
    drive_req(32'h100, 2'b10, 1'b0, 32'h0);
    wait_ack(ok);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({access_0a, mode_0a, do_0a} !== 3'b110 || en_cnt != e0) bad_hold = 1'b1;
    end
    drop_req();
    wait_resp(o2);
    snap = {abort_0r1d, abort_0r0d, di_0r1d, di_0r0d, 2'b00};
    abort_0a = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if ({abort_0r1d, abort_0r0d, di_0r1d, di_0r0d, 2'b00} !== snap) bad_stable = 1'b1;
    end
    di_0a = 1'b1;
    wait_rtz(o3);
    abort_0a = 1'b0; di_0a = 1'b0;
    repeat (SS + 3) @(negedge clk);
    n_chk++; if ({ok, o2, o3} !== 3'b111) begin n_fail++; $display("FAIL sl_handshake: got %b expected 111", {ok, o2, o3}); end
    n_chk++; if (bad_hold !== 1'b0) begin n_fail++; $display("FAIL sl_ack_hold: got unstable acks or early access, expected held"); end
    n_chk++; if (bad_stable !== 1'b0) begin n_fail++; $display("FAIL sl_resp_hold: got changing rails, expected stable"); end
    n_chk++; if (snap[67:34] !== {2'b01, 32'h11223344}) begin
      n_fail++; $display("FAIL sl_data: got %h expected 1_11223344", snap[67:34]);
    end
  endtask

  task automatic test_proto();
    logic acked; int e0;
    e0 = en_cnt; acked = 1'b0;
    @(negedge clk);
    drive_req(32'h300, 2'b10, 1'b0, 32'h0);
    access_0r1d[5] = 1'b1;
    access_0r0d[5] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (access_0a !== 1'b0) acked = 1'b1;
    end
    n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_flag: got %b expected 1", proto_err); end
    n_chk++; if ({acked, en_cnt - e0} !== {1'b0, 32'd0}) begin
      n_fail++; $display("FAIL pe_no_ack: got ack=%b accesses=%0d expected 0 0", acked, en_cnt - e0);
    end
    drop_req();
    repeat (8) @(negedge clk);
    n_chk++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL pe_sticky: got %b expected 1", proto_err); end
  endtask

  task automatic test_reset_resp();
    logic ok, o2; logic [1:0] ab; logic [31:0] r1, r0;
    @(negedge clk);
    drive_req(32'h104, 2'b10, 1'b0, 32'h0);
    wait_ack(ok);
    drop_req();
    wait_resp(o2);
    n_chk++; if ({ok, o2} !== 2'b11) begin n_fail++; $display("FAIL rr_reach_resp: got %b expected 11", {ok, o2}); end
    #2 nreset = 1'b0;
    #1;
    n_chk++;
    if ((|{access_0a, mode_0a, do_0a, di_0r0d, di_0r1d, abort_0r0d, abort_0r1d, mem_en, proto_err}) !== 1'b0) begin
      n_fail++; $display("FAIL rr_async_clear: got nonzero rails/acks expected all zero");
    end
    @(negedge clk); nreset = 1'b1;
    repeat (SS + 2) @(negedge clk);
    run_txn(32'h104, 2'b10, 1'b0, 32'h0, ok, ab, r1, r0);
    n_chk++; if ({ok, ab, r1} !== {1'b1, 2'b01, 32'h5566CCDD}) begin
      n_fail++; $display("FAIL rr_after: got ok=%b abort=%b di=%h expected 1 01 5566ccdd", ok, ab, r1);
    end
  endtask

  initial begin
    nreset = 1'b0;
    drop_req();
    di_0a = 1'b0;
    abort_0a = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_word_write();
    test_byte_read();
    test_half_write();
    test_abort();
    test_slow();
    test_proto();
    test_reset_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
